single_channel_io_arbiter: RTL

- Round-robin arbiter that shares one byte-wide SingleChannelIO slave (memory/bus port) among NUM_MASTERS SingleChannelIO masters.
- Typical masters: the instruction-fetch/data transfer converter, a DMA engine and a debug port.
- A grant is locked for the whole multi-byte sequence. The granted master keeps taskValid high across its bytes, so its sequence is never interleaved with another master's.
- Sits between the per-requester byte converters and the single external memory channel.

---
 rtl/single_channel_io_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/single_channel_io_arbiter.sv
// Round-robin arbiter sharing one byte-wide SingleChannelIO slave among NUM_MASTERS masters.
// Optional stall timeout is compiled in when SCIO_ARB_TIMEOUT_EN is defined.
module single_channel_io_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_W         = 40,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_task_valid,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
  input  logic [NUM_MASTERS-1:0]        m_rw_ctrl,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_write_bus,
  output logic [NUM_MASTERS-1:0]        m_task_ready,
  output logic [NUM_MASTERS-1:0]        m_task_error,
  output logic [DATA_W-1:0]             m_read_bus,
  output logic                          s_task_valid,
  output logic [ADDR_W-1:0]             s_address,
  output logic                          s_rw_ctrl,
  output logic [DATA_W-1:0]             s_write_bus,
  input  logic                          s_task_ready,
  input  logic                          s_task_error,
  input  logic [DATA_W-1:0]             s_read_bus,
  output logic [NUM_MASTERS-1:0]        grant,
  output logic                          busy
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  logic [0:0]             r_state;
  logic [NUM_MASTERS-1:0] r_grant;
  // r_last doubles as the owner index while in OWN.
  logic [IDX_W-1:0]       r_last;

  logic                   w_own;
  logic                   w_owner_valid;
  logic                   w_to_fire;
  logic                   w_any_req;
  logic [IDX_W-1:0]       w_pick_idx;

  logic [ADDR_W-1:0]      w_addr_arr  [NUM_MASTERS];
  logic [DATA_W-1:0]      w_wdata_arr [NUM_MASTERS];

  assign w_own         = (r_state == ST_OWN);
  assign w_owner_valid = m_task_valid[r_last];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      assign w_addr_arr[gi]   = m_address[gi*ADDR_W +: ADDR_W];
      assign w_wdata_arr[gi]  = m_write_bus[gi*DATA_W +: DATA_W];
      assign m_task_ready[gi] = w_own & r_grant[gi] & (s_task_ready | w_to_fire);
      assign m_task_error[gi] = w_own & r_grant[gi] & (s_task_error | w_to_fire);
    end
  endgenerate

  // Scan downward so the closest requester after r_last is the final (winning) assignment.
  always_comb begin
    int cand;
    cand       = 0;
    w_any_req  = 1'b0;
    w_pick_idx = r_last;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      cand = (int'(r_last) + k) % NUM_MASTERS;
      if (m_task_valid[IDX_W'(cand)]) begin
        w_any_req  = 1'b1;
        w_pick_idx = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_last  <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state <= ST_OWN;
            r_grant <= NUM_MASTERS'(1) << w_pick_idx;
            r_last  <= w_pick_idx;
          end
        end
        ST_OWN: begin
          if (!w_owner_valid) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

`ifdef SCIO_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_to_cnt;
  logic       w_stall;

  // Fires on the stalled cycle whose increment would reach TIMEOUT_CYCLES.
  assign w_stall   = w_own & w_owner_valid & ~s_task_ready;
  assign w_to_fire = w_stall & (r_to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_cnt <= '0;
    end else if (!w_stall || w_to_fire) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 8'd1;
    end
  end
`else
  assign w_to_fire = 1'b0;
`endif

  assign s_task_valid = w_own & w_owner_valid & ~w_to_fire;
  assign s_address    = w_own ? w_addr_arr[r_last] : '0;
  assign s_rw_ctrl    = w_own & m_rw_ctrl[r_last];
  assign s_write_bus  = w_own ? w_wdata_arr[r_last] : '0;

  assign m_read_bus   = s_read_bus;
  assign grant        = r_grant;
  assign busy         = w_own;

endmodule
